// File: rtl/hop_sched_ctrl.sv
// Frequency-hop scheduler: sequences local sync, then per hop scan load, hop sync and transmit windows.
// Outputs are registered or decoded from state; a scan load waits on scan_ack, and a hop ends on hop_done.
module hop_sched_ctrl #(
  parameter int PHASE_WIDTH    = 24,
  parameter int CODE_WIDTH     = 32,
  parameter int HOP_ADDR_WIDTH = 6,
  parameter int SYNC_LEN       = 16384,
  parameter int START_PH_INC   = 8192,
  parameter int HOP_DPH_INC    = 131072
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cfg_we,
  input  logic [HOP_ADDR_WIDTH-1:0] cfg_addr,
  input  logic [CODE_WIDTH-1:0]     cfg_wdata,
  input  logic [HOP_ADDR_WIDTH:0]   num_hops,
  input  logic                      enable,
  input  logic                      loop,
  output logic                      scan_req,
  output logic [CODE_WIDTH-1:0]     scan_code,
  input  logic                      scan_ack,
  input  logic                      hop_done,
  output logic                      sync_out,
  output logic                      tx_en,
  output logic                      hop_start,
  output logic [PHASE_WIDTH-1:0]    phase_inc,
  output logic [HOP_ADDR_WIDTH-1:0] hop_idx,
  output logic                      run_done,
  output logic                      busy
);

  localparam int DEPTH = 1 << HOP_ADDR_WIDTH;
  localparam int CNT_W = (SYNC_LEN > 1) ? $clog2(SYNC_LEN) : 1;
  localparam logic [CNT_W-1:0]          SYNC_LAST = CNT_W'(SYNC_LEN - 1);
  localparam logic [PHASE_WIDTH-1:0]    PH_START  = PHASE_WIDTH'(START_PH_INC);
  localparam logic [PHASE_WIDTH-1:0]    PH_STEP   = PHASE_WIDTH'(HOP_DPH_INC);
  localparam logic [HOP_ADDR_WIDTH:0]   MAX_HOPS  = (HOP_ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOC_SYNC,
    S_LOAD,
    S_HOP_SYNC,
    S_HOP_TX
  } state_t;

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [HOP_ADDR_WIDTH-1:0] hop_idx_q, hop_idx_d;
  logic [PHASE_WIDTH-1:0]    phase_inc_q, phase_inc_d;
  logic [HOP_ADDR_WIDTH:0]   hops_q, hops_d;
  logic [CODE_WIDTH-1:0]     scan_code_q, scan_code_d;
  logic                      hop_start_q, hop_start_d;
  logic                      run_done_q, run_done_d;

  logic [CODE_WIDTH-1:0]     table_mem [DEPTH];
  logic [HOP_ADDR_WIDTH-1:0] rd_addr;
  logic                      load_entry;
  logic                      start_ok;
  logic                      last_hop;
  logic [HOP_ADDR_WIDTH:0]   hops_clamped;

  // No reset on the table; a same-cycle read sees the pre-write contents.
  always_ff @(posedge clk) begin
    if (cfg_we) table_mem[cfg_addr] <= cfg_wdata;
  end

  assign start_ok     = enable && (num_hops != '0);
  assign hops_clamped = (num_hops > MAX_HOPS) ? MAX_HOPS : num_hops;
  assign last_hop     = ({1'b0, hop_idx_q} + (HOP_ADDR_WIDTH + 1)'(1)) >= hops_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hop_idx_d   = hop_idx_q;
    phase_inc_d = phase_inc_q;
    hops_d      = hops_q;
    hop_start_d = 1'b0;
    run_done_d  = 1'b0;
    load_entry  = 1'b0;
    rd_addr     = hop_idx_q;

    if (state_q != S_IDLE && !enable) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_ok) begin
            state_d     = S_LOC_SYNC;
            hops_d      = hops_clamped;
            hop_idx_d   = '0;
            phase_inc_d = PH_START;
            cnt_d       = SYNC_LAST;
          end
        end
        S_LOC_SYNC: begin
          if (cnt_q == '0) begin
            state_d    = S_LOAD;
            load_entry = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        S_LOAD: begin
          if (scan_ack) begin
            state_d = S_HOP_SYNC;
            cnt_d   = SYNC_LAST;
          end
        end
        S_HOP_SYNC: begin
          if (cnt_q == '0) begin
            state_d     = S_HOP_TX;
            hop_start_d = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        S_HOP_TX: begin
          if (hop_done) begin
            if (!last_hop) begin
              state_d     = S_LOAD;
              hop_idx_d   = hop_idx_q + HOP_ADDR_WIDTH'(1);
              phase_inc_d = phase_inc_q + PH_STEP;
              load_entry  = 1'b1;
              rd_addr     = hop_idx_q + HOP_ADDR_WIDTH'(1);
            end else begin
              run_done_d = 1'b1;
              state_d    = S_IDLE;
              // Looping restarts exactly as a fresh start from IDLE would.
              if (loop && start_ok) begin
                state_d     = S_LOC_SYNC;
                hops_d      = hops_clamped;
                hop_idx_d   = '0;
                phase_inc_d = PH_START;
                cnt_d       = SYNC_LAST;
              end
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    scan_code_d = load_entry ? table_mem[rd_addr] : scan_code_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      hop_idx_q   <= '0;
      phase_inc_q <= PH_START;
      hops_q      <= '0;
      scan_code_q <= '0;
      hop_start_q <= 1'b0;
      run_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hop_idx_q   <= hop_idx_d;
      phase_inc_q <= phase_inc_d;
      hops_q      <= hops_d;
      scan_code_q <= scan_code_d;
      hop_start_q <= hop_start_d;
      run_done_q  <= run_done_d;
    end
  end

  assign scan_req  = (state_q == S_LOAD);
  assign sync_out  = (state_q == S_LOC_SYNC) || (state_q == S_HOP_SYNC);
  assign tx_en     = (state_q == S_HOP_TX);
  assign busy      = (state_q != S_IDLE);
  assign scan_code = scan_code_q;
  assign hop_start = hop_start_q;
  assign run_done  = run_done_q;
  assign phase_inc = phase_inc_q;
  assign hop_idx   = hop_idx_q;

endmodule
